// File: rtl/game_event_logger.sv
// game_event_logger
//   Watches the counter-game status stage (win/los/gameover/who) every clock,
//   turns each game event into a timestamped record and buffers the records
//   in a show-ahead FIFO that a host drains over a valid/ready stream. The game
//   is never stalled: events that cannot be stored are counted and discarded.
//
//   Handshake: ev_valid is high whenever the FIFO holds a record, and ev_data
//   is then the head record. The head is consumed on a rising clk edge where
//   ev_valid & ev_ready; while ev_valid & !ev_ready, ev_data/ev_valid hold.
//
// Ports
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   clear          synchronous flush: FIFO, timestamp, drop_cnt, overflow, FSM
//   win, los       level event inputs, one event per asserted cycle
//   gameover, who  gameover rising edge is an event; who is captured with it
//   ev_data        head record {code[1:0], who[1:0], ts[TS_W-1:0]}
//   ev_valid       FIFO non-empty
//   ev_ready       host accepts the head record
//   level          FIFO occupancy 0..DEPTH
//   drop_cnt       saturating count of discarded events
//   overflow       sticky flag, set when an event is lost to a full FIFO
//   draining       FSM state: 1 while in DRAIN
module game_event_logger #(
  parameter int DEPTH  = 8,
  parameter int TS_W   = 12,
  parameter int DROP_W = 8,
  localparam int RW    = TS_W + 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              win,
  input  logic              los,
  input  logic              gameover,
  input  logic [1:0]        who,
  output logic [RW-1:0]     ev_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [LW-1:0]     level,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overflow,
  output logic              draining
);

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               ovf_q, ovf_d;
  logic               g_q;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      mem_q [DEPTH];

  logic               rise, ev_any, multi, empty, full, push, pop, drop_evt;
  logic [1:0]         code, who_f;
  logic [RW-1:0]      rec;

  // Event decode: only the highest-priority event of a cycle becomes a record.
  assign rise   = gameover & ~g_q;
  assign ev_any = rise | win | los;
  assign multi  = (rise & (win | los)) | (win & los);
  assign code   = rise ? 2'b11 : (win ? 2'b10 : 2'b01);
  assign who_f  = rise ? who : 2'b00;
  assign rec    = {code, who_f, ts_q};

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == LW'(DEPTH));
  assign pop    = ~empty & ev_ready;

  always_comb begin
    state_d  = state_q;
    ts_d     = ts_q + TS_W'(1);
    push     = 1'b0;
    drop_evt = 1'b0;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_RUN: begin
        if (ev_any) begin
          // A pop in the same cycle frees the slot, so a full FIFO still accepts.
          if (full && !pop) begin
            drop_evt = 1'b1;
            ovf_d    = 1'b1;
          end else begin
            push = 1'b1;
            if (code == 2'b11) state_d = ST_DRAIN;
          end
        end
        if (multi) drop_evt = 1'b1;
      end
      ST_DRAIN: begin
        if (ev_any) drop_evt = 1'b1;
        // Restart the next game with a fresh timebase once the host has caught up.
        if (empty) begin
          state_d = ST_RUN;
          ts_d    = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase

    drop_d = drop_q;
    if (drop_evt && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      ts_q     <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      g_q      <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      g_q <= gameover;
      if (clear) begin
        // clear wins over any same-cycle event or pop.
        state_q  <= ST_RUN;
        ts_q     <= '0;
        drop_q   <= '0;
        ovf_q    <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        state_q <= state_d;
        ts_q    <= ts_d;
        drop_q  <= drop_d;
        ovf_q   <= ovf_d;
        cnt_q   <= cnt_d;
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= rec;
  end

  assign ev_valid = ~empty;
  assign ev_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = cnt_q;
  assign drop_cnt = drop_q;
  assign overflow = ovf_q;
  assign draining = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_game_event_logger.sv
module tb_game_event_logger;

  localparam int DEPTH = 8;
  localparam int TS_W  = 12;
  localparam int DROPW = 8;
  localparam int RW    = TS_W + 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROPW) - 1;
  localparam int TS_MOD   = 1 << TS_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            clear = 1'b0, win = 1'b0, los = 1'b0, gameover = 1'b0;
  logic [1:0]      who = 2'b00;
  logic            ev_ready = 1'b0;
  logic [RW-1:0]   ev_data;
  logic            ev_valid;
  logic [LW-1:0]   level;
  logic [DROPW-1:0] drop_cnt;
  logic            overflow, draining;

  game_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROPW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .win(win), .los(los),
    .gameover(gameover), .who(who), .ev_data(ev_data), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .level(level), .drop_cnt(drop_cnt),
    .overflow(overflow), .draining(draining)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Records the host should see, oldest first, plus the logger's bookkeeping.
  logic [RW-1:0] exp_q[$];
  int m_level, m_ts, m_drop;
  bit m_ovf, m_drain, m_g;

  task automatic model_reset();
    exp_q.delete();
    m_level = 0; m_ts = 0; m_drop = 0;
    m_ovf = 0; m_drain = 0; m_g = 0;
  endtask

  // Outcome of one clock edge given the inputs held during the cycle.
  task automatic model_step();
    bit rise, pop, lost;
    int n_ev, next_ts;
    logic [1:0] c, w;
    logic [TS_W-1:0] ts_v;
    rise = gameover && !m_g;
    m_g  = gameover;
    if (clear) begin
      exp_q.delete();
      m_level = 0; m_ts = 0; m_drop = 0; m_ovf = 0; m_drain = 0;
      return;
    end
    n_ev = int'(rise) + int'(win) + int'(los);
    pop  = (m_level > 0) && ev_ready;
    lost = 0;
    next_ts = (m_ts + 1) % TS_MOD;
    if (m_drain) begin
      if (n_ev > 0) lost = 1;
      if (m_level == 0) begin
        m_drain = 0;
        next_ts = 0;
      end
    end else if (n_ev > 0) begin
      if (rise)     begin c = 2'b11; w = who;   end
      else if (win) begin c = 2'b10; w = 2'b00; end
      else          begin c = 2'b01; w = 2'b00; end
      if (n_ev > 1) lost = 1;
      if (m_level == DEPTH && !pop) begin
        lost = 1;
        m_ovf = 1;
      end else begin
        ts_v = TS_W'(m_ts);
        exp_q.push_back({c, w, ts_v});
        m_level++;
        if (c == 2'b11) m_drain = 1;
      end
    end
    if (pop) m_level--;
    if (lost && m_drop < DROP_MAX) m_drop++;
    m_ts = next_ts;
  endtask

  always @(posedge clk) if (reset_n) model_step();

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      check("level", 32'(level), 32'(m_level));
      check("ev_valid", 32'(ev_valid), 32'(m_level > 0));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("draining", 32'(draining), 32'(m_drain));
      if (ev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 32'(ev_data), 32'hFFFF_FFFF);
        end else begin
          check("ev_data", 32'(ev_data), 32'(exp_q[0]));
          if (ev_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ev_valid", 32'(ev_valid), 32'd0);
    check("reset_ev_data", 32'(ev_data), 32'd0);
    reset_n = 1'b1;

    // win at ts=5 with host ready
    ev_ready = 1'b1;
    repeat (5) cyc();
    win = 1'b1;
    cyc();
    win = 1'b0;
    @(negedge clk);
    check("t2_valid", 32'(ev_valid), 32'd1);
    check("t2_data", 32'(ev_data), 32'({2'b10, 2'b00, 12'd5}));
    cyc();
    @(negedge clk);
    check("t2_level", 32'(level), 32'd0);

    // ten los cycles into a stalled host
    ev_ready = 1'b0;
    cyc();
    do_clear();
    los = 1'b1;
    repeat (10) cyc();
    los = 1'b0;
    @(negedge clk);
    check("t3_level", 32'(level), 32'd8);
    check("t3_drop", 32'(drop_cnt), 32'd2);
    check("t3_ovf", 32'(overflow), 32'd1);
    ev_ready = 1'b1;
    repeat (10) cyc();
    @(negedge clk);
    check("t3_drained", 32'(level), 32'd0);

    // full FIFO, pop and push in the same cycle
    ev_ready = 1'b0;
    cyc();
    do_clear();
    los = 1'b1;
    repeat (8) cyc();
    los = 1'b0;
    ev_ready = 1'b1;
    win = 1'b1;
    cyc();
    win = 1'b0;
    ev_ready = 1'b0;
    @(negedge clk);
    check("t5_level", 32'(level), 32'd8);
    check("t5_drop", 32'(drop_cnt), 32'd0);

    // gameover with simultaneous win, then drain
    do_clear();
    gameover = 1'b1; who = 2'b10; win = 1'b1;
    cyc();
    win = 1'b0;
    @(negedge clk);
    check("t4_draining", 32'(draining), 32'd1);
    check("t4_drop", 32'(drop_cnt), 32'd1);
    check("t4_head", 32'(ev_data), 32'({2'b11, 2'b10, 12'd0}));
    repeat (3) begin
      win = 1'b1; cyc();
      win = 1'b0; cyc();
    end
    @(negedge clk);
    check("t4_drop_pulses", 32'(drop_cnt), 32'd4);
    ev_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check("t4_run_again", 32'(draining), 32'd0);
    win = 1'b1;
    cyc();
    win = 1'b0;
    @(negedge clk);
    check("t4_ts_restart", 32'(ev_data), 32'({2'b10, 2'b00, 12'd0}));
    cyc();

    // drop counter saturation, then clear
    gameover = 1'b0;
    ev_ready = 1'b0;
    do_clear();
    gameover = 1'b1; who = 2'b01;
    cyc();
    win = 1'b1;
    repeat (260) cyc();
    win = 1'b0;
    @(negedge clk);
    check("t6_saturate", 32'(drop_cnt), 32'(DROP_MAX));
    do_clear();
    @(negedge clk);
    check("t6_clr_level", 32'(level), 32'd0);
    check("t6_clr_drop", 32'(drop_cnt), 32'd0);
    check("t6_clr_ovf", 32'(overflow), 32'd0);
    gameover = 1'b0;
    win = 1'b1;
    cyc();
    win = 1'b0;
    @(negedge clk);
    check("t6_ts_zero", 32'(ev_data), 32'({2'b10, 2'b00, 12'd0}));

    // asynchronous reset mid-run, no clock edge
    los = 1'b1;
    repeat (3) cyc();
    los = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t1_valid", 32'(ev_valid), 32'd0);
    check("t1_level", 32'(level), 32'd0);
    check("t1_drop", 32'(drop_cnt), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_draining", 32'(draining), 32'd0);
    model_reset();
    #1;
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      win      = ($urandom_range(0, 7) == 0);
      los      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 30) == 0) gameover = ~gameover;
      who      = $urandom_range(1, 2) == 1 ? 2'b01 : 2'b10;
      ev_ready = (i % 400 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      clear    = ($urandom_range(0, 250) == 0);
      cyc();
    end

    // quiet down and let everything drain
    win = 1'b0; los = 1'b0; gameover = 1'b0; clear = 1'b0; ev_ready = 1'b1;
    repeat (30) cyc();
    @(negedge clk);
    check("final_empty", 32'(level), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
